uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ------------
// UART receiver with a configurable frame format (5-9 data bits, none/odd/even
// parity, 1 or 2 stop bits) and a small show-ahead FIFO on the output side.
// Each received character is stored with its own parity and framing error
// flags and handed to the consumer over a valid/ready handshake.
//
// Ports
//   clock           system clock, everything on the rising edge
//   reset           synchronous, active-high reset
//   serial_in       asynchronous UART line (idles high)
//   o_data          data bits of the FIFO head entry
//   o_parity_err    parity error flag of the head entry
//   o_frame_err     framing error flag of the head entry
//   o_valid         FIFO holds at least one entry
//   i_ready         consumer takes the head entry when o_valid is high
//   o_overrun       sticky: a character was dropped because the FIFO was full
//   i_clear_overrun clears o_overrun (a simultaneous new overrun wins)
//   o_busy          receiver FSM is not idle
//   o_count         number of entries held in the FIFO
module uart_rx_fifo #(
  parameter  int CLKS_PER_BIT = 868,
  parameter  int DATA_BITS    = 8,
  parameter  int PARITY       = 0,
  parameter  int STOP_BITS    = 1,
  parameter  int FIFO_DEPTH   = 4,
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overrun,
  input  logic                 i_clear_overrun,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_count
);

  localparam int CLK_W   = $clog2(CLKS_PER_BIT);
  localparam int BIT_W   = 4;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_BITS + 2;

  localparam logic [CLK_W-1:0] MID_CNT   = CLK_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CLK_W-1:0] LAST_CNT  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Two-flop synchroniser; both flops reset high so the line looks idle.
  // --------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic rx;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx = sync2_q;

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               state_q;
  logic [CLK_W-1:0]     clk_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 frame_err_q;

  logic                 sample_tick;
  logic                 par_xor;
  logic                 push_w;
  logic [ENTRY_W-1:0]   push_entry;

  // After the mid-start sample the counter restarts from zero, so every later
  // sample lands exactly CLKS_PER_BIT cycles after the previous one.
  assign sample_tick = (clk_cnt_q == LAST_CNT);
  assign par_xor     = ^{shift_q, rx};

  // The push happens on the very edge that takes the final stop sample, so
  // the frame error has to include the sample being taken right now.
  assign push_w     = (state_q == S_STOP) && sample_tick && (bit_cnt_q == STOP_LAST);
  assign push_entry = {par_err_q, frame_err_q | ~rx, shift_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          clk_cnt_q   <= '0;
          bit_cnt_q   <= '0;
          par_err_q   <= 1'b0;
          frame_err_q <= 1'b0;
          if (!rx) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (clk_cnt_q == MID_CNT) begin
            clk_cnt_q <= '0;
            // A line already back high at mid-start was a glitch.
            state_q   <= rx ? S_IDLE : S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CLK_W'(1);
          end
        end

        S_DATA: begin
          if (sample_tick) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CLK_W'(1);
          end
        end

        S_PARITY: begin
          if (sample_tick) begin
            clk_cnt_q <= '0;
            // Odd mode expects the total XOR to be 1, even mode expects 0.
            par_err_q <= (PARITY == 1) ? ~par_xor : par_xor;
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CLK_W'(1);
          end
        end

        S_STOP: begin
          if (sample_tick) begin
            clk_cnt_q   <= '0;
            frame_err_q <= frame_err_q | ~rx;
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_q <= '0;
              // A low final stop bit may be a break; wait for the line to
              // recover before looking for another start edge.
              state_q   <= rx ? S_IDLE : S_WAIT_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CLK_W'(1);
          end
        end

        S_WAIT_IDLE: begin
          if (rx) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state_q != S_IDLE);

  // --------------------------------------------------------------------------
  // Show-ahead FIFO. Storage is a plain array; the head entry is kept in a
  // separate register so the outputs are registered and hold their last
  // value once the FIFO runs empty.
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic               overrun_q, overrun_d;

  logic               empty;
  logic               full;
  logic               pop_w;
  logic               push_do;
  logic               drop_w;
  logic               bypass;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop_w   = !empty && i_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_do = push_w && (!full || pop_w);
  assign drop_w  = push_w && full && !pop_w;
  // The incoming entry becomes the new head when nothing else will be left.
  assign bypass  = push_do && (pop_w ? (count_q == CNT_W'(1)) : empty);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;
    overrun_d = overrun_q;

    if (push_do) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_do, pop_w})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (count_d != '0) begin
      if (bypass) begin
        head_d = push_entry;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end

    if (drop_w) begin
      overrun_d = 1'b1;
    end else if (i_clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push_do) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data       = head_q[DATA_BITS-1:0];
  assign o_frame_err  = head_q[DATA_BITS];
  assign o_parity_err = head_q[DATA_BITS+1];
  assign o_valid      = !empty;
  assign o_count      = count_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: 16 clocks per bit, 8 data bits, even parity,
// one stop bit, 4-entry FIFO. Frames are driven by a bit-level driver.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int PAR   = 2;
  localparam int SB    = 1;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          serial_in = 1'b1;
  logic          i_ready = 1'b0;
  logic          i_clear_overrun = 1'b0;
  logic [DB-1:0] o_data;
  logic          o_parity_err;
  logic          o_frame_err;
  logic          o_valid;
  logic          o_overrun;
  logic          o_busy;
  logic [CW-1:0] o_count;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .PARITY      (PAR),
    .STOP_BITS   (SB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .serial_in      (serial_in),
    .o_data         (o_data),
    .o_parity_err   (o_parity_err),
    .o_frame_err    (o_frame_err),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_overrun      (o_overrun),
    .i_clear_overrun(i_clear_overrun),
    .o_busy         (o_busy),
    .o_count        (o_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          perr;
    logic          ferr;
    logic [DB-1:0] data;
  } entry_t;

  entry_t got_q[$];
  entry_t exp_q[$];
  int     valid_cycles = 0;
  bit     rand_ready_en = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       pbit;
    logic       stopb;
    int         low_extra;
    logic [7:0] exp_d;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  // Records every entry the consumer actually takes.
  always @(negedge clock) begin
    if (!reset && o_valid) begin
      valid_cycles++;
      if (i_ready) begin
        got_q.push_back({o_parity_err, o_frame_err, o_data});
      end
    end
  end

  // Random consumer back-pressure for the randomized section.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_ready_en) begin
        i_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bit_out(input logic b);
    serial_in = b;
    cyc(CPB);
  endtask

  // Drives one frame; a low stop bit keeps the line low for low_extra more
  // cycles (receiver must still be busy) before the line returns to idle.
  task automatic send_frame(input logic [7:0] d, input logic pbit,
                            input logic stopb, input int low_extra);
    bit_out(1'b0);
    for (int i = 0; i < DB; i++) begin
      bit_out(d[i]);
    end
    bit_out(pbit);
    bit_out(stopb);
    if (!stopb) begin
      cyc(low_extra);
      check("wait_idle_busy", 32'(o_busy), 32'd1);
    end
    serial_in = 1'b1;
    cyc(2 * CPB);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(o_valid),      32'd0);
    check({tag, "_count"},   32'(o_count),      32'd0);
    check({tag, "_busy"},    32'(o_busy),       32'd0);
    check({tag, "_overrun"}, 32'(o_overrun),    32'd0);
    check({tag, "_data"},    32'(o_data),       32'd0);
    check({tag, "_perr"},    32'(o_parity_err), 32'd0);
    check({tag, "_ferr"},    32'(o_frame_err),  32'd0);
  endtask

  initial begin
    entry_t e;
    logic [7:0] d;
    logic pb;
    logic sb;
    int   seen;
    logic [7:0] v77;

    //            d      pbit  stop extra exp_d  perr  ferr
    vecs[0] = '{8'h0F, 1'b0, 1'b1, 0,  8'h0F, 1'b0, 1'b0};
    vecs[1] = '{8'hAB, 1'b0, 1'b1, 0,  8'hAB, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 40, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 0,  8'h55, 1'b0, 1'b0};
    vecs[4] = '{8'hAB, 1'b1, 1'b1, 0,  8'hAB, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 0,  8'h00, 1'b1, 1'b0};

    // Reset state
    reset = 1'b1;
    cyc(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    i_ready = 1'b1;
    cyc(5);

    // Table-driven single frames with the consumer always ready
    for (int v = 0; v < 6; v++) begin
      got_q.delete();
      valid_cycles = 0;
      send_frame(vecs[v].d, vecs[v].pbit, vecs[v].stopb, vecs[v].low_extra);
      check($sformatf("vec%0d_entries", v), 32'(got_q.size()), 32'd1);
      if (got_q.size() >= 1) begin
        check($sformatf("vec%0d_data", v), 32'(got_q[0].data), 32'(vecs[v].exp_d));
        check($sformatf("vec%0d_perr", v), 32'(got_q[0].perr), 32'(vecs[v].exp_perr));
        check($sformatf("vec%0d_ferr", v), 32'(got_q[0].ferr), 32'(vecs[v].exp_ferr));
      end
      check($sformatf("vec%0d_valid_cycles", v), 32'(valid_cycles), 32'd1);
      check($sformatf("vec%0d_busy_after", v), 32'(o_busy), 32'd0);
      check($sformatf("vec%0d_count_after", v), 32'(o_count), 32'd0);
    end

    // Short low glitch: false start, nothing stored
    got_q.delete();
    serial_in = 1'b0;
    cyc(4);
    serial_in = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_busy) seen = 1;
      cyc(1);
    end
    check("glitch_busy_rose", 32'(seen), 32'd1);
    cyc(20);
    check("glitch_busy_after", 32'(o_busy), 32'd0);
    check("glitch_count", 32'(o_count), 32'd0);
    check("glitch_entries", 32'(got_q.size()), 32'd0);

    // Overrun: five frames into a 4-deep FIFO with no consumer
    i_ready = 1'b0;
    got_q.delete();
    for (int k = 1; k <= 5; k++) begin
      d = 8'(k);
      send_frame(d, ^d, 1'b1, 0);
    end
    check("ovr_count", 32'(o_count), 32'd4);
    check("ovr_flag", 32'(o_overrun), 32'd1);
    check("ovr_valid", 32'(o_valid), 32'd1);
    check("ovr_head", 32'(o_data), 32'h01);
    i_clear_overrun = 1'b1;
    cyc(1);
    i_clear_overrun = 1'b0;
    check("ovr_cleared", 32'(o_overrun), 32'd0);
    i_ready = 1'b1;
    cyc(10);
    check("drain_entries", 32'(got_q.size()), 32'd4);
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      check($sformatf("drain%0d_data", k), 32'(got_q[k].data), 32'(k + 1));
      check($sformatf("drain%0d_errs", k), 32'({got_q[k].perr, got_q[k].ferr}), 32'd0);
    end
    check("drain_count", 32'(o_count), 32'd0);
    check("drain_hold_data", 32'(o_data), 32'h04);

    // Reset during data bit 3 of 0x77
    got_q.delete();
    v77 = 8'h77;
    serial_in = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 3; i++) begin
      bit_out(v77[i]);
    end
    serial_in = v77[3];
    cyc(8);
    check("midreset_busy_before", 32'(o_busy), 32'd1);
    reset = 1'b1;
    serial_in = 1'b1;
    cyc(1);
    reset = 1'b0;
    check_reset_outputs("midreset");
    cyc(30);
    check("midreset_idle", 32'(o_busy), 32'd0);
    check("midreset_no_entry", 32'(got_q.size()), 32'd0);
    send_frame(8'hC3, ^(8'hC3), 1'b1, 0);
    check("after_reset_entries", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) begin
      check("after_reset_data", 32'(got_q[0].data), 32'hC3);
      check("after_reset_errs", 32'({got_q[0].perr, got_q[0].ferr}), 32'd0);
    end

    // Randomized frames under random back-pressure vs. reference model
    got_q.delete();
    exp_q.delete();
    rand_ready_en = 1'b1;
    for (int n = 0; n < 12; n++) begin
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      // Even parity: the data bits plus the parity bit must XOR to 0.
      e.data = d;
      e.perr = (^d) ^ pb;
      e.ferr = ~sb;
      exp_q.push_back(e);
      send_frame(d, pb, sb, int'($urandom_range(0, 30)));
    end
    rand_ready_en = 1'b0;
    cyc(1);
    i_ready = 1'b1;
    cyc(10);
    check("rand_entries", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check($sformatf("rand%0d_entry", k), 32'(got_q[k]), 32'(exp_q[k]));
    end
    check("rand_no_overrun", 32'(o_overrun), 32'd0);
    check("rand_count", 32'(o_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
